ili_bus_arbiter: RTL and testbench

Shares the single ILI9341 byte serializer between two command/data requesters: requester 0 is the power-up init sequencer and requester 1 is the pixel/window writer. Each requester drives a chip-select/dc/data/send bundle exactly as it would drive the serializer directly. The arbiter grants one whole CS-low transaction at a time, round-robin. It enforces a CS-high guard gap between transactions and reports transaction status.

---
 rtl/ili_bus_arbiter.sv | 109 ++++++++++
 tb/tb_ili_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ili_bus_arbiter.sv
// Round-robin owner of the single ILI9341 byte serializer: grants whole CS-low
// transactions to the init sequencer (r0) or the pixel writer (r1), then forces a CS-high guard.
module ili_bus_arbiter #(
  parameter int DW  = 8,
  parameter int GAP = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_cs,
  input  logic          r0_dc,
  input  logic [DW-1:0] r0_data,
  input  logic          r0_send,
  output logic          r0_sent,
  output logic          r0_gnt,
  input  logic          r1_cs,
  input  logic          r1_dc,
  input  logic [DW-1:0] r1_data,
  input  logic          r1_send,
  output logic          r1_sent,
  output logic          r1_gnt,
  output logic          cs,
  output logic          dc,
  output logic [DW-1:0] data,
  output logic          send,
  input  logic          sent,
  output logic          busy,
  output logic [CW-1:0] byte_cnt
);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GUARD} state_t;

  state_t                 state, state_n;
  logic                   last, inflight;
  logic [GW-1:0]          gcnt;
  logic [1:0]             rq_cs, rq_dc, rq_send, sentv, gntv;
  logic [1:0][DW-1:0]     rq_data;
  logic                   sel, granted, pending;

  assign rq_cs   = {r1_cs, r0_cs};
  assign rq_dc   = {r1_dc, r0_dc};
  assign rq_send = {r1_send, r0_send};
  assign rq_data = {r1_data, r0_data};

  assign sel     = (state == GNT1);
  assign granted = (state == GNT0) || (state == GNT1);
  // A byte counts as outstanding from the moment send is shown, so CS can never
  // rise underneath a byte the serializer has already latched.
  assign pending = inflight || rq_send[sel];

  assign r0_sent = sentv[0];
  assign r1_sent = sentv[1];
  assign r0_gnt  = gntv[0];
  assign r1_gnt  = gntv[1];
  assign busy    = (state != IDLE);

  always_comb begin
    state_n = state;
    cs      = 1'b1;
    dc      = 1'b1;
    data    = '0;
    send    = 1'b0;
    sentv   = 2'b00;
    gntv    = 2'b00;
    case (state)
      IDLE: begin
        if (!rq_cs[0] && (rq_cs[1] || last)) state_n = GNT0;
        else if (!rq_cs[1])                  state_n = GNT1;
      end
      GNT0, GNT1: begin
        cs         = rq_cs[sel] && !pending;
        dc         = rq_dc[sel];
        data       = rq_data[sel];
        send       = rq_send[sel];
        sentv[sel] = sent;
        gntv[sel]  = 1'b1;
        if (rq_cs[sel] && (!pending || sent)) state_n = GUARD;
      end
      GUARD: begin
        if (gcnt == GW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      inflight <= 1'b0;
      gcnt     <= GW'(GAP);
      byte_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == GNT0) last <= 1'b0;
      if (state == IDLE && state_n == GNT1) last <= 1'b1;

      if (!granted || sent) inflight <= 1'b0;
      else if (send)        inflight <= 1'b1;

      if (state != GUARD && state_n == GUARD) gcnt <= GW'(GAP);
      else if (state == GUARD)                gcnt <= gcnt - GW'(1);

      if (state == IDLE && state_n != IDLE)             byte_cnt <= '0;
      else if (granted && sent && byte_cnt != {CW{1'b1}}) byte_cnt <= byte_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_ili_bus_arbiter.sv
// Directed bench for ili_bus_arbiter; a CW=2 copy shares the stimulus to exercise saturation.
module tb_ili_bus_arbiter;
  logic       clk = 1'b0, rst = 1'b0;
  logic       r0_cs = 1'b1, r0_dc = 1'b0, r0_send = 1'b0;
  logic       r1_cs = 1'b1, r1_dc = 1'b0, r1_send = 1'b0;
  logic [7:0] r0_data = '0, r1_data = '0;
  logic       sent = 1'b0;
  logic       r0_sent, r0_gnt, r1_sent, r1_gnt, cs, dc, send, busy;
  logic [7:0] data, byte_cnt;
  logic       s_r0_sent, s_r0_gnt, s_r1_sent, s_r1_gnt, s_cs, s_dc, s_send, s_busy;
  logic [7:0] s_data;
  logic [1:0] s_byte_cnt;

  int n_cmp = 0, n_bad = 0, aa_leak = 0;
  logic got_s0, got_s1, got_cs, got_dc;
  logic [7:0] got_data;

  ili_bus_arbiter #(.DW(8), .GAP(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .r0_cs(r0_cs), .r0_dc(r0_dc), .r0_data(r0_data), .r0_send(r0_send), .r0_sent(r0_sent), .r0_gnt(r0_gnt),
    .r1_cs(r1_cs), .r1_dc(r1_dc), .r1_data(r1_data), .r1_send(r1_send), .r1_sent(r1_sent), .r1_gnt(r1_gnt),
    .cs(cs), .dc(dc), .data(data), .send(send), .sent(sent), .busy(busy), .byte_cnt(byte_cnt));

  ili_bus_arbiter #(.DW(8), .GAP(4), .CW(2)) u_sat (
    .clk(clk), .rst(rst),
    .r0_cs(r0_cs), .r0_dc(r0_dc), .r0_data(r0_data), .r0_send(r0_send), .r0_sent(s_r0_sent), .r0_gnt(s_r0_gnt),
    .r1_cs(r1_cs), .r1_dc(r1_dc), .r1_data(r1_data), .r1_send(r1_send), .r1_sent(s_r1_sent), .r1_gnt(s_r1_gnt),
    .cs(s_cs), .dc(s_dc), .data(s_data), .send(s_send), .sent(sent), .busy(s_busy), .byte_cnt(s_byte_cnt));

  always #5 clk = ~clk;

  always @(negedge clk) if (r0_gnt && send === 1'b1 && data === 8'hAA) aa_leak++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Requester presents a byte; the serializer acks in the 8th cycle.
  task automatic do_byte(input int r, input logic dcv, input logic [7:0] d);
    if (r == 0) begin r0_dc = dcv; r0_data = d; r0_send = 1'b1; end
    else        begin r1_dc = dcv; r1_data = d; r1_send = 1'b1; end
    repeat (7) tick();
    sent = 1'b1;
    @(negedge clk);
    got_s0 = r0_sent; got_s1 = r1_sent; got_cs = cs; got_dc = dc; got_data = data;
    tick();
    sent = 1'b0;
    if (r == 0) r0_send = 1'b0; else r1_send = 1'b0;
  endtask

  task automatic wait_gnt(output int g);
    g = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (r0_gnt) begin g = 0; break; end
      if (r1_gnt) begin g = 1; break; end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0; r0_cs = 1'b1; r1_cs = 1'b1; r0_send = 1'b0; r1_send = 1'b0; sent = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (cs !== 1'b1 || send !== 1'b0) begin n_bad++; $display("FAIL rst_por_cs_send got=%b%b want=10", cs, send); end
    n_cmp++; if (dc !== 1'b1 || data !== 8'h00) begin n_bad++; $display("FAIL rst_por_dc_data got=%b/%h want=1/00", dc, data); end
    n_cmp++; if ({r0_gnt, r1_gnt, r0_sent, r1_sent, busy} !== 5'b0 || byte_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_por_status got=%b cnt=%0d want=00000 cnt=0", {r0_gnt, r1_gnt, r0_sent, r1_sent, busy}, byte_cnt); end
    tick(); rst = 1'b1; tick();
    r0_cs = 1'b0; tick();
    do_byte(0, 1'b0, 8'h36);
    n_cmp++; if (byte_cnt !== 8'd1) begin n_bad++; $display("FAIL rst_pre_cnt got=%0d want=1", byte_cnt); end
    r0_dc = 1'b1; r0_data = 8'h48; r0_send = 1'b1;
    tick(); tick();
    @(negedge clk); #2;
    rst = 1'b0; #1;
    n_cmp++; if (cs !== 1'b1 || send !== 1'b0) begin n_bad++; $display("FAIL rst_mid_cs_send got=%b%b want=10", cs, send); end
    n_cmp++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_gnt_busy got=%b%b%b want=000", r0_gnt, r1_gnt, busy); end
    n_cmp++; if (byte_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_mid_cnt got=%0d want=0", byte_cnt); end
    r0_cs = 1'b1; r0_send = 1'b0;
    tick(); rst = 1'b1; tick();
  endtask

  task automatic test_single();
    int n;
    r0_cs = 1'b0;
    @(negedge clk);
    n_cmp++; if (r0_gnt !== 1'b0) begin n_bad++; $display("FAIL single_gnt_early got=%b want=0", r0_gnt); end
    tick();
    n_cmp++; if (r0_gnt !== 1'b1 || cs !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_gnt got=%b%b%b want=101", r0_gnt, cs, busy); end
    do_byte(0, 1'b0, 8'h36);
    n_cmp++; if ({got_s0, got_cs, got_dc} !== 3'b100 || got_data !== 8'h36) begin n_bad++; $display("FAIL single_b0 got=%b/%h want=100/36", {got_s0, got_cs, got_dc}, got_data); end
    do_byte(0, 1'b1, 8'h48);
    n_cmp++; if ({got_s0, got_cs, got_dc} !== 3'b101 || got_data !== 8'h48) begin n_bad++; $display("FAIL single_b1 got=%b/%h want=101/48", {got_s0, got_cs, got_dc}, got_data); end
    n_cmp++; if (byte_cnt !== 8'd2) begin n_bad++; $display("FAIL single_cnt got=%0d want=2", byte_cnt); end
    r0_cs = 1'b1;
    tick();
    n_cmp++; if (cs !== 1'b1 || busy !== 1'b1 || r0_gnt !== 1'b0) begin n_bad++; $display("FAIL single_guard got=%b%b%b want=110", cs, busy, r0_gnt); end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!busy) break;
      n++;
    end
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL single_guard_len got=%0d want=4", n); end
    n_cmp++; if (byte_cnt !== 8'd2) begin n_bad++; $display("FAIL single_cnt_hold got=%0d want=2", byte_cnt); end
  endtask

  task automatic test_stray_sent();
    sent = 1'b1;
    @(negedge clk);
    n_cmp++; if (r0_sent !== 1'b0 || r1_sent !== 1'b0) begin n_bad++; $display("FAIL stray_sent got=%b%b want=00", r0_sent, r1_sent); end
    tick(); sent = 1'b0;
    n_cmp++; if (byte_cnt !== 8'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL stray_cnt got=%0d/%b want=2/0", byte_cnt, busy); end
  endtask

  task automatic test_tie();
    int g;
    int expv [4] = '{0, 1, 0, 1};
    logic ok;
    reset_dut();
    r0_cs = 1'b0; r1_cs = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      n_cmp++; if (g !== expv[k]) begin n_bad++; $display("FAIL tie_order%0d got=%0d want=%0d", k, g, expv[k]); end
      if (g < 0) break;
      do_byte(g, 1'b1, 8'h10 + 8'(k));
      if (g == 0) r0_cs = 1'b1; else r1_cs = 1'b1;
      tick();
      if (g == 0) r0_cs = 1'b0; else r1_cs = 1'b0;
    end
    r0_cs = 1'b1; r1_cs = 1'b1;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tie_idle got=%b want=1", ok); end
  endtask

  task automatic test_late_release();
    int g;
    logic ok;
    r1_cs = 1'b0;
    wait_gnt(g);
    n_cmp++; if (g !== 1) begin n_bad++; $display("FAIL late_gnt got=%0d want=1", g); end
    r1_dc = 1'b1; r1_data = 8'h5A; r1_send = 1'b1;
    tick(); tick();
    r1_cs = 1'b1;
    @(negedge clk);
    n_cmp++; if (cs !== 1'b0 || send !== 1'b1 || r1_gnt !== 1'b1) begin n_bad++; $display("FAIL late_hold got=%b%b%b want=011", cs, send, r1_gnt); end
    tick(); tick();
    sent = 1'b1;
    @(negedge clk);
    n_cmp++; if (cs !== 1'b0 || r1_sent !== 1'b1) begin n_bad++; $display("FAIL late_sent got=%b%b want=01", cs, r1_sent); end
    tick();
    sent = 1'b0; r1_send = 1'b0;
    n_cmp++; if (cs !== 1'b1 || busy !== 1'b1 || r1_gnt !== 1'b0) begin n_bad++; $display("FAIL late_guard got=%b%b%b want=110", cs, busy, r1_gnt); end
    n_cmp++; if (byte_cnt !== 8'd1) begin n_bad++; $display("FAIL late_cnt got=%0d want=1", byte_cnt); end
    wait_idle(ok);
  endtask

  task automatic test_isolation();
    int g, n;
    logic ok;
    aa_leak = 0;
    r0_cs = 1'b0;
    wait_gnt(g);
    n_cmp++; if (g !== 0) begin n_bad++; $display("FAIL iso_gnt got=%0d want=0", g); end
    r1_cs = 1'b0; r1_dc = 1'b0; r1_data = 8'hAA; r1_send = 1'b1;
    do_byte(0, 1'b0, 8'h2A);
    n_cmp++; if (got_s1 !== 1'b0 || got_data !== 8'h2A) begin n_bad++; $display("FAIL iso_byte got=%b/%h want=0/2a", got_s1, got_data); end
    r0_cs = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (r1_gnt) break;
      n++;
    end
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL iso_wait got=%0d want=6", n); end
    n_cmp++; if (aa_leak !== 0) begin n_bad++; $display("FAIL iso_leak got=%0d want=0", aa_leak); end
    n_cmp++; if (data !== 8'hAA || send !== 1'b1) begin n_bad++; $display("FAIL iso_r1_data got=%h/%b want=aa/1", data, send); end
    tick();
    sent = 1'b1;
    @(negedge clk);
    n_cmp++; if (r1_sent !== 1'b1 || r0_sent !== 1'b0) begin n_bad++; $display("FAIL iso_r1_sent got=%b%b want=10", r1_sent, r0_sent); end
    tick();
    sent = 1'b0; r1_send = 1'b0; r1_cs = 1'b1;
    wait_idle(ok);
  endtask

  task automatic test_saturation();
    int g;
    logic ok;
    r0_cs = 1'b0;
    wait_gnt(g);
    for (int i = 0; i < 5; i++) do_byte(0, 1'b1, 8'(i));
    n_cmp++; if (byte_cnt !== 8'd5) begin n_bad++; $display("FAIL sat_wide got=%0d want=5", byte_cnt); end
    n_cmp++; if (s_byte_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_narrow got=%0d want=3", s_byte_cnt); end
    r0_cs = 1'b1;
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1 || s_byte_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_hold got=%b/%0d want=1/3", ok, s_byte_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stray_sent();
    test_tie();
    test_late_release();
    test_isolation();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
